// File: rtl/sys_bus_router.sv
// sys_bus_router: routes single-outstanding system bus requests to SLAVES sub-buses.
// Define SYS_BUS_ROUTER_TIMEOUT_EN to compile in the acknowledge timeout counter.
module sys_bus_router #(
   parameter int SLAVES  = 8,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SEL_LSB = 20,
   parameter int TIMEOUT = 255
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   input  logic [AW-1:0]        sys_addr_i,
   input  logic [DW-1:0]        sys_wdata_i,
   input  logic [DW/8-1:0]      sys_sel_i,
   input  logic                 sys_wen_i,
   input  logic                 sys_ren_i,
   output logic [DW-1:0]        sys_rdata_o,
   output logic                 sys_err_o,
   output logic                 sys_ack_o,
   output logic [AW-1:0]        sub_addr_o,
   output logic [DW-1:0]        sub_wdata_o,
   output logic [DW/8-1:0]      sub_sel_o,
   output logic [SLAVES-1:0]    sub_wen_o,
   output logic [SLAVES-1:0]    sub_ren_o,
   input  logic [SLAVES*DW-1:0] sub_rdata_i,
   input  logic [SLAVES-1:0]    sub_err_i,
   input  logic [SLAVES-1:0]    sub_ack_i
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] NSLV = 4'(SLAVES);

   state_t        state;
   logic [2:0]    idx;
   logic          is_wr;
   logic          miss;
   logic          req;
   logic [2:0]    req_idx;
   logic          req_hit;
   logic          cur_ack;
   logic          cur_err;
   logic [DW-1:0] cur_rdata;

`ifdef SYS_BUS_ROUTER_TIMEOUT_EN
   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
   logic       tmo;
   assign tmo = (cnt == TLAST);
`endif

   assign req     = sys_wen_i | sys_ren_i;
   assign req_idx = sys_addr_i[SEL_LSB+2:SEL_LSB];
   assign req_hit = ({1'b0, req_idx} < NSLV);

   // Select the addressed slave's response lines.
   always_comb begin
      cur_ack   = 1'b0;
      cur_err   = 1'b0;
      cur_rdata = '0;
      for (int k = 0; k < SLAVES; k++) begin
         if (idx == 3'(k)) begin
            cur_ack   = sub_ack_i[k];
            cur_err   = sub_err_i[k];
            cur_rdata = sub_rdata_i[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state       <= IDLE;
         idx         <= '0;
         is_wr       <= 1'b0;
         miss        <= 1'b0;
         sys_rdata_o <= '0;
         sys_err_o   <= 1'b0;
         sys_ack_o   <= 1'b0;
         sub_addr_o  <= '0;
         sub_wdata_o <= '0;
         sub_sel_o   <= '0;
         sub_wen_o   <= '0;
         sub_ren_o   <= '0;
`ifdef SYS_BUS_ROUTER_TIMEOUT_EN
         cnt         <= '0;
`endif
      end else begin
         sub_wen_o <= '0;
         sub_ren_o <= '0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  sub_addr_o  <= sys_addr_i;
                  sub_wdata_o <= sys_wdata_i;
                  sub_sel_o   <= sys_sel_i;
                  idx         <= req_idx;
                  is_wr       <= sys_wen_i;
                  miss        <= !req_hit;
                  // Write wins over a simultaneous read.
                  for (int k = 0; k < SLAVES; k++) begin
                     sub_wen_o[k] <= sys_wen_i && (req_idx == 3'(k));
                     sub_ren_o[k] <= !sys_wen_i && (req_idx == 3'(k));
                  end
`ifdef SYS_BUS_ROUTER_TIMEOUT_EN
                  cnt <= '0;
`endif
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (miss) begin
                  sys_ack_o   <= 1'b1;
                  sys_err_o   <= 1'b1;
                  sys_rdata_o <= '0;
                  state       <= RESP;
               end else if (cur_ack) begin
                  sys_ack_o   <= 1'b1;
                  sys_err_o   <= cur_err;
                  sys_rdata_o <= is_wr ? '0 : cur_rdata;
                  state       <= RESP;
`ifdef SYS_BUS_ROUTER_TIMEOUT_EN
               end else if (tmo) begin
                  sys_ack_o   <= 1'b1;
                  sys_err_o   <= 1'b1;
                  sys_rdata_o <= '0;
                  state       <= RESP;
               end else if (cnt != 8'hff) begin
                  cnt <= cnt + 8'd1;
`endif
               end
            end
            RESP: begin
               sys_ack_o   <= 1'b0;
               sys_err_o   <= 1'b0;
               sys_rdata_o <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sys_bus_router.sv
// tb_sys_bus_router: randomized scoreboard bench for sys_bus_router (SLAVES=4, TIMEOUT=16).
// Expected timeout behaviour follows SYS_BUS_ROUTER_TIMEOUT_EN.
module tb_sys_bus_router;

   localparam int SLV   = 4;
   localparam int TMO   = 16;
   localparam int NEVER = 100000;
`ifdef SYS_BUS_ROUTER_TIMEOUT_EN
   localparam bit TEN = 1'b1;
`else
   localparam bit TEN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       sys_addr = '0;
   logic [31:0]       sys_wdata = '0;
   logic [3:0]        sys_sel = '0;
   logic              wen = 1'b0;
   logic              ren = 1'b0;
   logic [31:0]       sys_rdata;
   logic              sys_err;
   logic              sys_ack;
   logic [31:0]       sub_addr;
   logic [31:0]       sub_wdata;
   logic [3:0]        sub_sel;
   logic [SLV-1:0]    sub_wen;
   logic [SLV-1:0]    sub_ren;
   logic [SLV*32-1:0] sub_rdata = '0;
   logic [SLV-1:0]    sub_err = '0;
   logic [SLV-1:0]    sub_ack = '0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          at;
   } exp_t;

   typedef struct {
      logic [3:0]  wen;
      logic [3:0]  ren;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
   } stb_t;

   exp_t exp_q[$];
   stb_t stb_q[$];
   exp_t me;
   stb_t ms;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ack_cnt = 0;

   sys_bus_router #(
      .SLAVES(SLV), .AW(32), .DW(32), .SEL_LSB(20), .TIMEOUT(TMO)
   ) dut (
      .sys_clk_i  (clk),
      .sys_rst_i  (rst),
      .sys_addr_i (sys_addr),
      .sys_wdata_i(sys_wdata),
      .sys_sel_i  (sys_sel),
      .sys_wen_i  (wen),
      .sys_ren_i  (ren),
      .sys_rdata_o(sys_rdata),
      .sys_err_o  (sys_err),
      .sys_ack_o  (sys_ack),
      .sub_addr_o (sub_addr),
      .sub_wdata_o(sub_wdata),
      .sub_sel_o  (sub_sel),
      .sub_wen_o  (sub_wen),
      .sub_ren_o  (sub_ren),
      .sub_rdata_i(sub_rdata),
      .sub_err_i  (sub_err),
      .sub_ack_i  (sub_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: strobes and responses are popped against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         if ((sub_wen | sub_ren) != '0) begin
            if (stb_q.size() == 0) begin
               chk("stray_strobe", 64'({sub_wen, sub_ren}), 64'd0);
            end else begin
               ms = stb_q.pop_front();
               chk("strobe_wen", 64'(sub_wen), 64'(ms.wen));
               chk("strobe_ren", 64'(sub_ren), 64'(ms.ren));
               chk("sub_addr", 64'(sub_addr), 64'(ms.addr));
               chk("sub_wdata", 64'(sub_wdata), 64'(ms.wdata));
               chk("sub_sel", 64'(sub_sel), 64'(ms.sel));
            end
         end
         if (sys_ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", 64'(sys_ack), 64'd0);
            end else begin
               me = exp_q.pop_front();
               chk("ack_cycle", 64'(cyc), 64'(me.at));
               chk("rdata", 64'(sys_rdata), 64'(me.rdata));
               chk("err", 64'(sys_err), 64'(me.err));
            end
         end else begin
            chk("idle_resp", 64'({sys_err, sys_rdata}), 64'd0);
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 64'({sys_ack, sys_err, sub_wen, sub_ren, sub_sel}), 64'd0);
      chk({tag, "_data"}, {sys_rdata, sub_wdata}, 64'd0);
      chk({tag, "_addr"}, 64'(sub_addr), 64'd0);
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero("rst_async");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue(input logic [31:0] addr, input bit w, input bit r,
                        input logic [31:0] wd);
      stb_t s;
      int   idx;
      idx = int'(addr[22:20]);
      @(negedge clk);
      sys_addr  = addr;
      sys_wdata = wd;
      sys_sel   = 4'($urandom);
      wen       = w;
      ren       = r;
      if (idx < SLV) begin
         s.wen   = w ? 4'(1 << idx) : 4'd0;
         s.ren   = (!w && r) ? 4'(1 << idx) : 4'd0;
         s.addr  = addr;
         s.wdata = wd;
         s.sel   = sys_sel;
         stb_q.push_back(s);
      end
      @(negedge clk);
      wen = 1'b0;
      ren = 1'b0;
   endtask

   // d: slave ack delay in cycles after its strobe cycle (NEVER = no ack).
   task automatic txn(input logic [31:0] addr, input bit w, input bit r,
                      input logic [31:0] wd, input int d, input bit drv,
                      input logic [31:0] rd, input bit er, input bit noise,
                      input bit inj);
      exp_t e;
      int   idx;
      int   lat;
      bit   resp;
      int   n;
      idx  = int'(addr[22:20]);
      resp = 1'b1;
      lat  = 0;
      e.rdata = '0;
      e.err   = 1'b0;
      e.at    = 0;
      if (idx >= SLV) begin
         e.err = 1'b1;
         lat   = 2;
      end else if (TEN && d >= TMO) begin
         e.err = 1'b1;
         lat   = TMO + 1;
      end else if (d >= NEVER) begin
         resp = 1'b0;
      end else begin
         e.rdata = w ? 32'd0 : rd;
         e.err   = er;
         lat     = d + 2;
      end
      if (drv) begin
         sub_ack   = noise ? SLV'($urandom) : '0;
         sub_err   = SLV'($urandom);
         sub_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (idx < SLV) begin
            sub_ack[idx]          = 1'b0;
            sub_err[idx]          = er;
            sub_rdata[idx*32+:32] = rd;
         end
      end
      issue(addr, w, r, wd);
      if (resp) begin
         e.at = cyc - 1 + lat;
         exp_q.push_back(e);
      end
      fork
         begin
            if (drv && idx < SLV && d < NEVER) begin
               repeat (d) @(negedge clk);
               sub_ack[idx] = 1'b1;
               @(negedge clk);
               sub_ack[idx] = 1'b0;
            end
         end
         begin
            if (inj) begin
               @(negedge clk);
               sys_addr = 32'h0030_0000;
               ren      = 1'b1;
               @(negedge clk);
               ren = 1'b0;
            end
         end
      join
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("resp_arrived", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      chk("strobe_seen", 64'(stb_q.size()), 64'd0);
      stb_q.delete();
      if (drv) sub_ack = '0;
   endtask

   initial begin
      int          n0;
      int          m;
      logic [31:0] a;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      rst = 1'b0;
      @(negedge clk);

      // Write with slave 0 ack held high permanently.
      sub_ack = 4'b0001;
      sub_err = '0;
      txn(32'h0000_0000, 1'b1, 1'b0, 32'h6666_6666, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      sub_ack = '0;

      // Read slave 2 with delayed ack.
      txn(32'h0020_0004, 1'b0, 1'b1, $urandom, 4, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

      // Unmapped index.
      txn(32'h0050_0000, 1'b0, 1'b1, $urandom, 0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);

      // Slave 1 never acks.
      n0 = ack_cnt;
      txn(32'h0010_0000, 1'b0, 1'b1, $urandom, NEVER, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef SYS_BUS_ROUTER_TIMEOUT_EN
      @(negedge clk);
      sub_ack[1] = 1'b1;
      @(negedge clk);
      sub_ack[1] = 1'b0;
      repeat (5) @(negedge clk);
      chk("late_ack_ignored", 64'(ack_cnt - n0), 64'd1);
`else
      repeat (1000) @(negedge clk);
      chk("no_resp_no_timeout", 64'(ack_cnt - n0), 64'd0);
      rst_pulse();
      @(negedge clk);
`endif

      // Simultaneous write+read, plus a request injected during WAIT.
      n0 = ack_cnt;
      txn(32'h0000_0000, 1'b1, 1'b1, $urandom, 5, 1'b1, $urandom, 1'b0, 1'b0, 1'b1);
      chk("single_ack", 64'(ack_cnt - n0), 64'd1);

      // Reset while waiting on slave 2.
      issue(32'h0020_0000, 1'b0, 1'b1, $urandom);
      repeat (3) @(negedge clk);
      n0 = ack_cnt;
      rst_pulse();
      repeat (25) @(negedge clk);
      chk("rst_no_ack", 64'(ack_cnt - n0), 64'd0);
      chk("rst_strobe_seen", 64'(stb_q.size()), 64'd0);
      stb_q.delete();
      txn(32'h0000_0008, 1'b1, 1'b0, $urandom, 0, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);

      // Ack on the last wait edge, then one cycle too late.
      txn(32'h0030_0010, 1'b0, 1'b1, $urandom, TMO - 1, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      txn(32'h0030_0020, 1'b0, 1'b1, $urandom, TMO, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         m = $urandom_range(0, 2);
         a = $urandom;
         txn(a, m != 1, m != 0, $urandom, $urandom_range(0, 6), 1'b1,
             $urandom, 1'($urandom), 1'b1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
